// File: rtl/fir_stream_kernel.sv
// fir_stream_kernel: block-level (ap_start/ap_ready/ap_done/ap_idle) FIR kernel, one MAC per cycle over NTAPS taps.
// Latency: start seen T0, input handshake T1, MAC T2..T(NTAPS+1), result valid T(NTAPS+2); NTAPS+2 cycles per result back-to-back.
// Backpressure: A_V_TREADY only in READ; B_V_TVALID/B_V_TDATA held in WRITE until B_V_TREADY, ap_done pulses the cycle after.
//
// Ports:
//   ap_clk, ap_rst            kernel clock (okClk), async active-high reset
//   ap_start/ready/done/idle  block-level control handshake
//   A_V_*                     input sample stream, bits [17:0] signed sample
//   B_V_*                     48-bit signed result stream
//   coef_we/addr/din          coefficient load, accepted only in IDLE
//   flush                     present only with `define FIR_FLUSH_EN: clears the delay line from IDLE
// Constraint: CW <= 29 so a full product fits the 48-bit accumulator.
module fir_stream_kernel #(
  parameter int NTAPS = 16,
  parameter int CW    = 18
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_ready,
  output logic          ap_done,
  output logic          ap_idle,
  input  logic [23:0]   A_V_TDATA,
  input  logic          A_V_TVALID,
  output logic          A_V_TREADY,
  output logic [47:0]   B_V_TDATA,
  output logic          B_V_TVALID,
  input  logic          B_V_TREADY,
  input  logic          coef_we,
  input  logic [5:0]    coef_addr,
  input  logic [CW-1:0] coef_din
`ifdef FIR_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  localparam int AW  = $clog2(NTAPS);
  localparam int PW  = 18 + CW;
  localparam int PAD = 48 - PW;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MAC, S_WRITE} state_t;

  state_t state_q, state_d;

  logic signed [17:0]   dly_q  [NTAPS];
  logic signed [CW-1:0] coef_q [NTAPS];
  logic [AW-1:0]        idx_q;
  logic [47:0]          acc_q;

  logic                 a_hs;
  logic                 b_hs;
  logic                 last_tap;
  logic signed [PW-1:0] prod;
  logic [47:0]          prod_ext;
  logic [AW-1:0]        waddr;
  logic                 coef_wr;
  logic                 unused_bits;

  // Upper address bits alias onto the low taps; upper sample bits carry no data.
  assign unused_bits = ^{coef_addr, A_V_TDATA[23:18]};

  assign waddr    = coef_addr[AW-1:0];
  // Range check only matters when NTAPS is not a power of two.
  assign coef_wr  = coef_we && (state_q == S_IDLE) && ({1'b0, waddr} < (AW+1)'(NTAPS));
  assign last_tap = (idx_q == AW'(NTAPS - 1));

  assign prod     = PW'(dly_q[idx_q]) * PW'(coef_q[idx_q]);
  assign prod_ext = {{PAD{prod[PW-1]}}, prod};

  assign a_hs      = A_V_TREADY && A_V_TVALID;
  assign b_hs      = B_V_TVALID && B_V_TREADY;
  // acc is frozen outside MAC, so the result is stable for the whole WRITE state.
  assign B_V_TDATA = acc_q;

  always_comb begin
    state_d    = state_q;
    ap_idle    = 1'b0;
    A_V_TREADY = 1'b0;
    B_V_TVALID = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_d = S_READ;
      end
      S_READ: begin
        A_V_TREADY = 1'b1;
        if (A_V_TVALID) state_d = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_d = S_WRITE;
      end
      S_WRITE: begin
        B_V_TVALID = 1'b1;
        // A level-held start chains straight into the next invocation.
        if (B_V_TREADY) state_d = ap_start ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ap_ready <= a_hs;
      ap_done  <= b_hs;

      if (a_hs) begin
        dly_q[0] <= A_V_TDATA[17:0];
        for (int i = 1; i < NTAPS; i++) dly_q[i] <= dly_q[i-1];
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= acc_q + prod_ext;
        idx_q <= idx_q + AW'(1);
      end
`ifdef FIR_FLUSH_EN
      else if ((state_q == S_IDLE) && flush) begin
        for (int i = 0; i < NTAPS; i++) dly_q[i] <= '0;
      end
`endif

      if (coef_wr) coef_q[waddr] <= coef_din;
    end
  end

endmodule
